cgra4ml_axi2ram: RTL and testbench
==================================

# cgra4ml_axi2ram

Self-contained accelerator stand-in with an AXI-Lite control slave and three simple RAM-style memory ports: pixel read, weights read and output write. Software programs a 16-entry config register file plus a small side SDP config RAM over AXI-Lite, then starts a streaming job. The job reads pixel and weight beats, adds them bytewise, and writes the result beats. The block is the DUT beneath the system-level DPI memory model, which services the RAM ports.

## Interface
- `C_S_AXI_DATA_WIDTH`, default 128: memory-port beat width; must be a power of two, at least 32.
- `C_S_AXI_ADDR_WIDTH`, default 32: byte-address width of the memory ports.
- `LSB`, default `$clog2(C_S_AXI_DATA_WIDTH)-3`: beat-to-byte address shift.
- `ADDR_WIDTH`, default 40: AXI-Lite address width.
- `DATA_WR_WIDTH` / `DATA_RD_WIDTH` / `STRB_WIDTH`, default 32/32/4: AXI-Lite data and strobe widths.
- `RAM_DEPTH`, default 16: words in the SDP config RAM.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous active-low reset.
- `s_axil_aw*`, `s_axil_w*`, `s_axil_b*`, `s_axil_ar*`, `s_axil_r*`: standard AXI-Lite slave. `prot` is ignored. Widths are as given by the parameters; `resp` is 2 bits.
- `o_rd_pixel`  out  1: pixel read strobe.
- `o_raddr_pixel`  out  `C_S_AXI_ADDR_WIDTH-LSB`: pixel beat address.
- `i_rdata_pixel`  in  `C_S_AXI_DATA_WIDTH`: pixel read data.
- `o_rd_weights`, `o_raddr_weights`, `i_rdata_weights`: same as the pixel port, for weights.
- `o_we_output`  out  1: output write strobe.
- `o_waddr_output`  out  `C_S_AXI_ADDR_WIDTH-LSB`: output beat address.
- `o_wdata_output`  out  `C_S_AXI_DATA_WIDTH`: output write data.
- `o_wstrb_output`  out  `C_S_AXI_DATA_WIDTH/8`: output byte enables.

## Operation
- Instance hierarchy: `OC_TOP.CONTROLLER` holds `cfg[0:15]` (32-bit) and `sdp_ram.RAM[0:RAM_DEPTH-1]`. A DPI model accesses these by hierarchical name.
- AXI-Lite byte-offset decode uses `addr[ADDR_WIDTH-1:2]` as the word index:
  - Byte offsets 0x00–0x3C map to `cfg[offset/4]`.
  - Byte offsets from 0x40 up to `0x40+4*RAM_DEPTH-4` map to `RAM[offset/4-16]`.
  - Writes beyond that range are ignored and reads return 0.
  - `resp` is always OKAY (0).
- Writes honour `wstrb` per byte.
- Register map:
  - `cfg[0]` CTRL: writing bit0=1 while idle starts a job. Bit0 reads back 0.
  - `cfg[1]` STATUS, read-only: bit0 busy; bit1 done. Done is sticky and is cleared by a start.
  - `cfg[2]` pixel base byte address.
  - `cfg[3]` weights base byte address.
  - `cfg[4]` output base byte address.
  - `cfg[5]` length in beats.
  - `cfg[6..15]` scratch.
- Bases are beat-aligned. Beat address is `base[C_S_AXI_ADDR_WIDTH-1:LSB] + i`, wrapping modulo `2^(C_S_AXI_ADDR_WIDTH-LSB)`.
- Engine FSM states: IDLE, READ, CAPTURE, WRITE, DONE.
  - IDLE to READ on start, provided length ≠ 0. If length is 0, go straight to DONE.
  - READ: pulse `o_rd_pixel` and `o_rd_weights` together, with addresses for beat i.
  - CAPTURE: register `i_rdata_pixel` and `i_rdata_weights`. The memory returns data one cycle after the strobe.
  - WRITE: pulse `o_we_output` at output beat i. Data is the bytewise modulo-256 sum of pixel and weights. `o_wstrb_output` is all ones. Increment i, then go to READ if i<length, otherwise DONE.
  - DONE: set the done bit, clear busy, and return to IDLE one cycle later.
- Writes to CTRL while busy are ignored. Writes to `cfg[2..5]` during a job take effect only at the next start, because the engine latches them at start.

## Timing
- Reset values: all outputs are 0, including `awready`, `wready`, `arready`, `bvalid` and `rvalid`. `cfg[*]` is 0. The SDP RAM is not reset.
- AXI-Lite write: `awready` and `wready` pulse high together for one cycle, only when `awvalid`, `wvalid` and `!bvalid` are all true. The register updates on that edge. `bvalid` rises the next cycle and holds until `bready`.
- AXI-Lite read: `arready` pulses when `arvalid && !rvalid`. `rvalid` and `rdata` appear the next cycle and hold until `rready`.
- Start: the register write on edge N puts the engine in READ at N+1 (busy readable at N+1). Each beat takes 3 cycles.
- Strobes are 1-cycle pulses; addresses and data are valid only while their strobe is high.
- Reset asserted mid-job aborts immediately: all strobes drop asynchronously and the FSM goes to IDLE.

## Test plan
1. Write 0x00001000 to 0x08, then read 0x08 → 0x00001000. Write wstrb=0x1 with data 0xFFFFFFFF to 0x0C → reads 0x000000FF.
2. Write 0xDEADBEEF to 0x44 → `RAM[1]`=0xDEADBEEF and readback matches. Read 0x1000 → 0.
3. Set pixel=0x100, weights=0x200, out=0x300, len=2, then start. Expect pixel reads at beats 0x10 and 0x11, weight reads at 0x20 and 0x21, and output writes at 0x30 and 0x31. With all pixel bytes 0x01 and all weight bytes 0xFF, write data is 0 and strobes are all ones. Done is set after 6 cycles.
4. len=0 plus start → no strobes; STATUS reads 0x2.
5. Hold `bready` low for 5 cycles → `bvalid` is held and no new write is accepted. Hold `rready` low → `rdata` is stable.
6. Drop `rstn` during WRITE → all outputs go to 0 immediately and `cfg` is cleared. After release, a new job runs normally.

Source files
------------

// File: rtl/cgra4ml_axi2ram.sv
// Accelerator stand-in: AXI-Lite config slave (cfg regs + SDP config RAM) driving a
// streaming engine that reads pixel/weight beats and writes their bytewise sum.

module cgra4ml_axi2ram_sdp_ram #(
  parameter int RAM_DEPTH = 16,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = 4,
  parameter int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [RAM_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [RAM_AW-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] RAM [0:RAM_DEPTH-1];

  // Contents are deliberately left unreset; software loads them before use.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) RAM[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = RAM[i_raddr];
endmodule

module cgra4ml_axi2ram_controller #(
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int LSB                = $clog2(C_S_AXI_DATA_WIDTH) - 3,
  parameter int ADDR_WIDTH         = 40,
  parameter int DATA_WR_WIDTH      = 32,
  parameter int DATA_RD_WIDTH      = 32,
  parameter int STRB_WIDTH         = 4,
  parameter int RAM_DEPTH          = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [ADDR_WIDTH-1:0]             s_axil_awaddr,
  input  logic [2:0]                        s_axil_awprot,
  input  logic                              s_axil_awvalid,
  output logic                              s_axil_awready,
  input  logic [DATA_WR_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]             s_axil_wstrb,
  input  logic                              s_axil_wvalid,
  output logic                              s_axil_wready,
  output logic [1:0]                        s_axil_bresp,
  output logic                              s_axil_bvalid,
  input  logic                              s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]             s_axil_araddr,
  input  logic [2:0]                        s_axil_arprot,
  input  logic                              s_axil_arvalid,
  output logic                              s_axil_arready,
  output logic [DATA_RD_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                        s_axil_rresp,
  output logic                              s_axil_rvalid,
  input  logic                              s_axil_rready,
  output logic                              o_rd_pixel,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_raddr_pixel,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     i_rdata_pixel,
  output logic                              o_rd_weights,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_raddr_weights,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     i_rdata_weights,
  output logic                              o_we_output,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_waddr_output,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     o_wdata_output,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   o_wstrb_output
);
  localparam int IW     = ADDR_WIDTH - 2;
  localparam int AW     = C_S_AXI_ADDR_WIDTH - LSB;
  localparam int NB     = C_S_AXI_DATA_WIDTH / 8;
  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [IW-1:0] CFG_WORDS = IW'(16);
  localparam logic [IW-1:0] RAM_END   = IW'(16 + RAM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] byte_add_mod256(
    input logic [C_S_AXI_DATA_WIDTH-1:0] a,
    input logic [C_S_AXI_DATA_WIDTH-1:0] b
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < NB; k++) s[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
    return s;
  endfunction

  logic [31:0] cfg [0:15];

  state_t                  r_state, w_state_nxt;
  logic                    r_awready, r_bvalid, r_arready, r_rvalid;
  logic [DATA_RD_WIDTH-1:0] r_rdata;
  logic [31:0]             r_idx, r_len;
  logic [AW-1:0]           r_pix_base, r_wgt_base, r_out_base;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_pix_p0, r_wgt_p0;

  logic [IW-1:0]           w_widx, w_ridx;
  logic                    w_wr_fire, w_rd_fire, w_wr_cfg, w_wr_ram, w_rd_cfg, w_rd_ram;
  logic [3:0]              w_wr_cfg_idx;
  logic [RAM_AW-1:0]       w_ram_widx, w_ram_ridx;
  logic [DATA_WR_WIDTH-1:0] w_ram_rdata;
  logic [DATA_RD_WIDTH-1:0] w_rd_word;
  logic                    w_start, w_busy_nxt, w_done_nxt, w_rd, w_we;
  logic [31:0]             w_idx_inc;
  logic                    w_unused;

  assign w_unused = &{1'b0, s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign w_widx       = s_axil_awaddr[ADDR_WIDTH-1:2];
  assign w_ridx       = s_axil_araddr[ADDR_WIDTH-1:2];
  assign w_wr_fire    = r_awready & s_axil_awvalid & s_axil_wvalid;
  assign w_rd_fire    = r_arready & s_axil_arvalid;
  assign w_wr_cfg     = (w_widx < CFG_WORDS);
  assign w_wr_ram     = !w_wr_cfg && (w_widx < RAM_END);
  assign w_rd_cfg     = (w_ridx < CFG_WORDS);
  assign w_rd_ram     = !w_rd_cfg && (w_ridx < RAM_END);
  assign w_wr_cfg_idx = w_widx[3:0];
  assign w_ram_widx   = RAM_AW'(w_widx - CFG_WORDS);
  assign w_ram_ridx   = RAM_AW'(w_ridx - CFG_WORDS);

  // A start is recognised on the same edge the CTRL write lands, so READ follows next cycle.
  assign w_start = w_wr_fire && w_wr_cfg && (w_wr_cfg_idx == 4'd0) &&
                   s_axil_wstrb[0] && s_axil_wdata[0] && (r_state == S_IDLE);

  cgra4ml_axi2ram_sdp_ram #(
    .RAM_DEPTH (RAM_DEPTH),
    .DATA_W    (DATA_WR_WIDTH),
    .STRB_W    (STRB_WIDTH),
    .RAM_AW    (RAM_AW)
  ) sdp_ram (
    .clk     (clk),
    .i_we    (w_wr_fire && w_wr_ram),
    .i_waddr (w_ram_widx),
    .i_wdata (s_axil_wdata),
    .i_wstrb (s_axil_wstrb),
    .i_raddr (w_ram_ridx),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_rd_word = '0;
    if (w_rd_cfg)      w_rd_word = DATA_RD_WIDTH'(cfg[w_ridx[3:0]]);
    else if (w_rd_ram) w_rd_word = DATA_RD_WIDTH'(w_ram_rdata);
  end

  // AXI-Lite channel handshakes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= s_axil_awvalid && s_axil_wvalid && !r_bvalid && !r_awready;
      if (w_wr_fire)          r_bvalid <= 1'b1;
      else if (s_axil_bready) r_bvalid <= 1'b0;
      r_arready <= s_axil_arvalid && !r_rvalid && !r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_word;
      end else if (s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_awready;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_arready = r_arready;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = 2'b00;
  assign s_axil_rvalid  = r_rvalid;

  assign w_idx_inc = r_idx + 32'd1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = (cfg[5] == 32'd0) ? S_DONE : S_READ;
      S_READ:    w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = (w_idx_inc < r_len) ? S_READ : S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy_nxt = w_state_nxt inside {S_READ, S_CAPTURE, S_WRITE};
  assign w_done_nxt = (w_state_nxt == S_DONE) || (cfg[1][1] && !w_start);

  // Register file: CTRL bit0 self-clears, STATUS mirrors the engine's next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) cfg[i] <= '0;
    end else begin
      if (w_wr_fire && w_wr_cfg && ((w_wr_cfg_idx != 4'd0) || (r_state == S_IDLE))) begin
        for (int b = 0; b < 4; b++) begin
          if (s_axil_wstrb[b]) cfg[w_wr_cfg_idx][8*b +: 8] <= s_axil_wdata[8*b +: 8];
        end
      end
      cfg[0][0] <= 1'b0;
      cfg[1]    <= {30'd0, w_done_nxt, w_busy_nxt};
    end
  end

  // Engine control; job parameters are latched at start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_pix_base <= '0;
      r_wgt_base <= '0;
      r_out_base <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_idx      <= '0;
        r_len      <= cfg[5];
        r_pix_base <= cfg[2][C_S_AXI_ADDR_WIDTH-1:LSB];
        r_wgt_base <= cfg[3][C_S_AXI_ADDR_WIDTH-1:LSB];
        r_out_base <= cfg[4][C_S_AXI_ADDR_WIDTH-1:LSB];
      end else if (r_state == S_WRITE) begin
        r_idx <= w_idx_inc;
      end
    end
  end

  // Capture stage: memory data arrives the cycle after the read strobe
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE) begin
      r_pix_p0 <= i_rdata_pixel;
      r_wgt_p0 <= i_rdata_weights;
    end
  end

  assign w_rd = (r_state == S_READ);
  assign w_we = (r_state == S_WRITE);

  assign o_rd_pixel      = w_rd;
  assign o_rd_weights    = w_rd;
  assign o_raddr_pixel   = w_rd ? r_pix_base + r_idx[AW-1:0] : '0;
  assign o_raddr_weights = w_rd ? r_wgt_base + r_idx[AW-1:0] : '0;
  assign o_we_output     = w_we;
  assign o_waddr_output  = w_we ? r_out_base + r_idx[AW-1:0] : '0;
  assign o_wdata_output  = w_we ? byte_add_mod256(r_pix_p0, r_wgt_p0) : '0;
  assign o_wstrb_output  = {NB{w_we}};
endmodule

module cgra4ml_axi2ram_oc_top #(
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int LSB                = $clog2(C_S_AXI_DATA_WIDTH) - 3,
  parameter int ADDR_WIDTH         = 40,
  parameter int DATA_WR_WIDTH      = 32,
  parameter int DATA_RD_WIDTH      = 32,
  parameter int STRB_WIDTH         = 4,
  parameter int RAM_DEPTH          = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [ADDR_WIDTH-1:0]             s_axil_awaddr,
  input  logic [2:0]                        s_axil_awprot,
  input  logic                              s_axil_awvalid,
  output logic                              s_axil_awready,
  input  logic [DATA_WR_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]             s_axil_wstrb,
  input  logic                              s_axil_wvalid,
  output logic                              s_axil_wready,
  output logic [1:0]                        s_axil_bresp,
  output logic                              s_axil_bvalid,
  input  logic                              s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]             s_axil_araddr,
  input  logic [2:0]                        s_axil_arprot,
  input  logic                              s_axil_arvalid,
  output logic                              s_axil_arready,
  output logic [DATA_RD_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                        s_axil_rresp,
  output logic                              s_axil_rvalid,
  input  logic                              s_axil_rready,
  output logic                              o_rd_pixel,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_raddr_pixel,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     i_rdata_pixel,
  output logic                              o_rd_weights,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_raddr_weights,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     i_rdata_weights,
  output logic                              o_we_output,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_waddr_output,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     o_wdata_output,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   o_wstrb_output
);
  cgra4ml_axi2ram_controller #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .LSB                (LSB),
    .ADDR_WIDTH         (ADDR_WIDTH),
    .DATA_WR_WIDTH      (DATA_WR_WIDTH),
    .DATA_RD_WIDTH      (DATA_RD_WIDTH),
    .STRB_WIDTH         (STRB_WIDTH),
    .RAM_DEPTH          (RAM_DEPTH)
  ) CONTROLLER (.*);
endmodule

module cgra4ml_axi2ram #(
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int LSB                = $clog2(C_S_AXI_DATA_WIDTH) - 3,
  parameter int ADDR_WIDTH         = 40,
  parameter int DATA_WR_WIDTH      = 32,
  parameter int DATA_RD_WIDTH      = 32,
  parameter int STRB_WIDTH         = 4,
  parameter int RAM_DEPTH          = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [ADDR_WIDTH-1:0]             s_axil_awaddr,
  input  logic [2:0]                        s_axil_awprot,
  input  logic                              s_axil_awvalid,
  output logic                              s_axil_awready,
  input  logic [DATA_WR_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]             s_axil_wstrb,
  input  logic                              s_axil_wvalid,
  output logic                              s_axil_wready,
  output logic [1:0]                        s_axil_bresp,
  output logic                              s_axil_bvalid,
  input  logic                              s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]             s_axil_araddr,
  input  logic [2:0]                        s_axil_arprot,
  input  logic                              s_axil_arvalid,
  output logic                              s_axil_arready,
  output logic [DATA_RD_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                        s_axil_rresp,
  output logic                              s_axil_rvalid,
  input  logic                              s_axil_rready,
  output logic                              o_rd_pixel,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_raddr_pixel,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     i_rdata_pixel,
  output logic                              o_rd_weights,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_raddr_weights,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     i_rdata_weights,
  output logic                              o_we_output,
  output logic [C_S_AXI_ADDR_WIDTH-LSB-1:0] o_waddr_output,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     o_wdata_output,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   o_wstrb_output
);
  cgra4ml_axi2ram_oc_top #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .LSB                (LSB),
    .ADDR_WIDTH         (ADDR_WIDTH),
    .DATA_WR_WIDTH      (DATA_WR_WIDTH),
    .DATA_RD_WIDTH      (DATA_RD_WIDTH),
    .STRB_WIDTH         (STRB_WIDTH),
    .RAM_DEPTH          (RAM_DEPTH)
  ) OC_TOP (.*);
endmodule

// File: tb/tb_cgra4ml_axi2ram.sv
// Directed bench for cgra4ml_axi2ram: AXI-Lite register/RAM access, streaming jobs,
// back-pressure on B/R channels and asynchronous reset during a job.

module tb_cgra4ml_axi2ram;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [39:0]  awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [39:0]  araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b1;
  logic         rd_pixel, rd_weights, we_output;
  logic [27:0]  raddr_pixel, raddr_weights, waddr_output;
  logic [127:0] rdata_pixel = '0, rdata_weights = '0, wdata_output;
  logic [15:0]  wstrb_output;

  logic [7:0]   pix_byte = 8'h00, wgt_byte = 8'h00;
  int           n_checks = 0, n_fail = 0;
  logic [31:0]  d;

  always #5 clk = ~clk;

  cgra4ml_axi2ram dut (
    .clk(clk), .rstn(rstn),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .o_rd_pixel(rd_pixel), .o_raddr_pixel(raddr_pixel), .i_rdata_pixel(rdata_pixel),
    .o_rd_weights(rd_weights), .o_raddr_weights(raddr_weights), .i_rdata_weights(rdata_weights),
    .o_we_output(we_output), .o_waddr_output(waddr_output), .o_wdata_output(wdata_output),
    .o_wstrb_output(wstrb_output)
  );

  // Memory model: data is returned one cycle after a read strobe, zero otherwise
  always @(posedge clk) begin
    rdata_pixel   <= rd_pixel   ? {16{pix_byte}} : '0;
    rdata_weights <= rd_weights ? {16{wgt_byte}} : '0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [39:0] a, input logic [31:0] dat, input logic [3:0] s,
                            input bit wait_b);
    logic seen;
    seen = 1'b0;
    awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = awready && wready;
    end
    check("aw_w_handshake", 128'(seen), 128'(1'b1));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (wait_b) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = bvalid;
      end
      check("bvalid_seen", 128'(seen), 128'(1'b1));
      check("bresp", 128'(bresp), 128'(2'b00));
      @(posedge clk); #1;
    end
  endtask

  task automatic axil_read(input logic [39:0] a, output logic [31:0] dat);
    logic seen;
    seen = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = arready;
    end
    check("ar_handshake", 128'(seen), 128'(1'b1));
    @(posedge clk); #1;
    arvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rvalid;
    end
    check("rvalid_seen", 128'(seen), 128'(1'b1));
    check("rresp", 128'(rresp), 128'(2'b00));
    dat = rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl_outs",
          128'({awready, wready, bvalid, arready, rvalid, rd_pixel, rd_weights, we_output}), 128'(8'h00));
    check("reset_data_outs", 128'({rdata, raddr_pixel, raddr_weights, waddr_output, wstrb_output}), 128'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    axil_read(40'h14, d);
    check("reset_cfg5", 128'(d), 128'(32'h0));

    // Register write/readback and byte strobes
    axil_write(40'h08, 32'h0000_1000, 4'hF, 1'b1);
    axil_read(40'h08, d);
    check("cfg2_readback", 128'(d), 128'(32'h0000_1000));
    axil_write(40'h0C, 32'hFFFF_FFFF, 4'h1, 1'b1);
    axil_read(40'h0C, d);
    check("cfg3_wstrb", 128'(d), 128'(32'h0000_00FF));

    // SDP RAM window and out-of-range accesses
    axil_write(40'h44, 32'hDEAD_BEEF, 4'hF, 1'b1);
    axil_read(40'h44, d);
    check("ram1_readback", 128'(d), 128'(32'hDEAD_BEEF));
    check("ram1_hier", 128'(dut.OC_TOP.CONTROLLER.sdp_ram.RAM[1]), 128'(32'hDEAD_BEEF));
    axil_write(40'h40, 32'h1111_1111, 4'hF, 1'b1);
    axil_write(40'h7C, 32'hCAFE_F00D, 4'hF, 1'b1);
    axil_write(40'h1000, 32'h1234_5678, 4'hF, 1'b1);
    axil_read(40'h1000, d);
    check("oob_read_1000", 128'(d), 128'(32'h0));
    axil_read(40'h40, d);
    check("ram0_not_aliased", 128'(d), 128'(32'h1111_1111));
    axil_read(40'h7C, d);
    check("ram_last_word", 128'(d), 128'(32'hCAFE_F00D));
    axil_read(40'h80, d);
    check("oob_read_80", 128'(d), 128'(32'h0));

    // Two-beat job: 0x01 + 0xFF per byte wraps to 0x00
    pix_byte = 8'h01; wgt_byte = 8'hFF;
    axil_write(40'h08, 32'h100, 4'hF, 1'b1);
    axil_write(40'h0C, 32'h200, 4'hF, 1'b1);
    axil_write(40'h10, 32'h300, 4'hF, 1'b1);
    axil_write(40'h14, 32'd2, 4'hF, 1'b1);
    axil_write(40'h00, 32'h1, 4'hF, 1'b0);
    @(negedge clk);
    check("j1_c1_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b110));
    check("j1_c1_pix_addr", 128'(raddr_pixel), 128'(28'h10));
    check("j1_c1_wgt_addr", 128'(raddr_weights), 128'(28'h20));
    check("j1_c1_busy", 128'(dut.OC_TOP.CONTROLLER.cfg[1]), 128'(32'h1));
    @(negedge clk);
    check("j1_c2_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b000));
    @(negedge clk);
    check("j1_c3_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b001));
    check("j1_c3_out_addr", 128'(waddr_output), 128'(28'h30));
    check("j1_c3_wdata", wdata_output, 128'(0));
    check("j1_c3_wstrb", 128'(wstrb_output), 128'(16'hFFFF));
    @(negedge clk);
    check("j1_c4_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b110));
    check("j1_c4_pix_addr", 128'(raddr_pixel), 128'(28'h11));
    check("j1_c4_wgt_addr", 128'(raddr_weights), 128'(28'h21));
    @(negedge clk);
    check("j1_c5_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b000));
    @(negedge clk);
    check("j1_c6_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b001));
    check("j1_c6_out_addr", 128'(waddr_output), 128'(28'h31));
    check("j1_c6_wdata", wdata_output, 128'(0));
    @(negedge clk);
    check("j1_c7_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b000));
    check("j1_c7_done", 128'(dut.OC_TOP.CONTROLLER.cfg[1]), 128'(32'h2));
    @(posedge clk); #1;
    axil_read(40'h04, d);
    check("j1_status", 128'(d), 128'(32'h2));
    axil_read(40'h00, d);
    check("ctrl_bit0_reads_0", 128'(d), 128'(32'h0));

    // Zero-length job goes straight to done
    axil_write(40'h14, 32'd0, 4'hF, 1'b1);
    axil_write(40'h00, 32'h1, 4'hF, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("len0_no_strobes", 128'({rd_pixel, rd_weights, we_output}), 128'(3'b000));
    end
    @(posedge clk); #1;
    axil_read(40'h04, d);
    check("len0_status", 128'(d), 128'(32'h2));

    // B channel back-pressure blocks further writes
    bready = 1'b0;
    axil_write(40'h18, 32'hA5A5_A5A5, 4'hF, 1'b0);
    awaddr = 40'h1C; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("b_hold", 128'({bvalid, awready}), 128'(2'b10));
    end
    @(posedge clk); #1;
    bready = 1'b1;
    axil_write(40'h1C, 32'h5A5A_5A5A, 4'hF, 1'b1);
    axil_read(40'h18, d);
    check("bp_first_write", 128'(d), 128'(32'hA5A5_A5A5));
    axil_read(40'h1C, d);
    check("bp_second_write", 128'(d), 128'(32'h5A5A_5A5A));

    // R channel back-pressure holds data
    rready = 1'b0;
    araddr = 40'h18; arvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("r_hold_arready", 128'(arready), 128'(1'b1));
    @(posedge clk); #1;
    arvalid = 1'b0; araddr = 40'h08;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("r_hold", 128'({rvalid, arready, rdata}), 128'({1'b1, 1'b0, 32'hA5A5_A5A5}));
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("r_released", 128'(rvalid), 128'(1'b0));
    @(posedge clk); #1;

    // Reset during WRITE aborts the job and clears the register file
    pix_byte = 8'h12; wgt_byte = 8'h34;
    axil_write(40'h14, 32'd4, 4'hF, 1'b1);
    axil_write(40'h00, 32'h1, 4'hF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_job_in_write", 128'({we_output, waddr_output}), 128'({1'b1, 28'h30}));
    check("rst_job_wdata", wdata_output, {16{8'h46}});
    rstn = 1'b0;
    #1;
    check("rst_strobes", 128'({rd_pixel, rd_weights, we_output, wstrb_output}), 128'(0));
    check("rst_addr_data", 128'({raddr_pixel, raddr_weights, waddr_output}), 128'(0));
    check("rst_wdata", wdata_output, 128'(0));
    check("rst_cfg", 128'({dut.OC_TOP.CONTROLLER.cfg[1], dut.OC_TOP.CONTROLLER.cfg[2],
                           dut.OC_TOP.CONTROLLER.cfg[5]}), 128'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 128'({rd_pixel, we_output}), 128'(2'b00));
    @(posedge clk); #1;

    // Fresh job after reset
    axil_write(40'h08, 32'h500, 4'hF, 1'b1);
    axil_write(40'h0C, 32'h600, 4'hF, 1'b1);
    axil_write(40'h10, 32'h700, 4'hF, 1'b1);
    axil_write(40'h14, 32'd1, 4'hF, 1'b1);
    axil_write(40'h00, 32'h1, 4'hF, 1'b0);
    @(negedge clk);
    check("j2_c1_read", 128'({rd_pixel, raddr_pixel, raddr_weights}), 128'({1'b1, 28'h50, 28'h60}));
    @(negedge clk);
    @(negedge clk);
    check("j2_c3_write", 128'({we_output, waddr_output, wstrb_output}), 128'({1'b1, 28'h70, 16'hFFFF}));
    check("j2_c3_wdata", wdata_output, {16{8'h46}});
    @(negedge clk);
    check("j2_c4_done", 128'({we_output, dut.OC_TOP.CONTROLLER.cfg[1]}), 128'({1'b0, 32'h2}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
